reg_dump_reader: RTL and testbench

- Read-side master for the pipeline register file. It drives the file's asynchronous read port and walks every register in turn, from address 0 up to the last one.
- Each register value is sent out as a beat on a valid/ready stream. Consumers are the debug/trace port and the end-of-test checker.
- The block is the read counterpart to the register file's synchronous write port. It does not write to the file.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/reg_dump_reader_chk.sv | 44 ++++
 rtl/reg_dump_reader.sv | 165 ++++++++++++++++
 tb/tb_reg_dump_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Types and constants shared between the pipeline register file and the
// blocks that read it.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default geometry of the register file
//   NUM_REGS                        : register count for the default geometry
//   num_regs()                      : register count for any address width
//   dump_state_e                    : state encoding of the dump reader FSM
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 2;

    // The file is always fully decoded, so the register count is a power of two.
    function automatic int num_regs(input int addr_width);
        return 32'sd1 << addr_width;
    endfunction

    localparam int NUM_REGS = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DONE   = 2'b10
    } dump_state_e;

endpackage

// File: rtl/reg_dump_reader_chk.sv
// -----------------------------------------------------------------------------
// reg_dump_reader_chk
// Protocol properties of the dump reader output stream. Purely observational;
// all ports are inputs taken from the reader's boundary.
//   clk, rst_n, abort, out_ready         : reader inputs
//   out_valid, out_data, out_addr,
//   out_last, busy, done                 : reader outputs
// -----------------------------------------------------------------------------
module reg_dump_reader_chk
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  abort,
    input logic                  out_ready,
    input logic                  out_valid,
    input logic [DATA_WIDTH-1:0] out_data,
    input logic [ADDR_WIDTH-1:0] out_addr,
    input logic                  out_last,
    input logic                  busy,
    input logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(num_regs(ADDR_WIDTH) - 1);

    // A stalled beat stays frozen unless abort or reset intervenes.
    a_hold_stable: assert property (@(posedge clk)
        (rst_n && out_valid && !out_ready && !abort) |=>
            (out_valid && $stable(out_data) && $stable(out_addr) && $stable(out_last)));

    // The last flag only ever marks a valid beat from the top register.
    a_last_addr: assert property (@(posedge clk)
        out_last |-> (out_valid && (out_addr == LAST_ADDR)));

    // Done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk) done |=> !done);

    // Busy and done never overlap.
    a_busy_done: assert property (@(posedge clk) !(busy && done));

endmodule

// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
// Walks every register of the pipeline register file through its asynchronous
// read port, address 0 first, and presents each value as one beat on a
// valid/ready stream.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begins a dump when sampled high in IDLE
//   abort      in   cancels a dump in progress (no done pulse)
//   busy       out  high while beats are being streamed
//   done       out  one-cycle pulse after the last beat is accepted
//   rf_raddr   out  register file read address (the fetch pointer)
//   rf_rdata   in   register file asynchronous read data for rf_raddr
//   out_valid  out  a beat is held in the output register
//   out_ready  in   consumer accepts the beat
//   out_data   out  register value of the held beat
//   out_addr   out  register address of the held beat
//   out_last   out  held beat is the highest register
// -----------------------------------------------------------------------------
module reg_dump_reader
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last
);

    localparam int                  NUM_REGS_P = num_regs(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS_P - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    dump_state_e           state_q,     state_d;
    logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic                  out_last_q,  out_last_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic                  xfer_s;
    logic                  load_s;

    assign xfer_s = out_valid_q & out_ready;

    // Next-state and output-register decode for the dump FSM.
    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        load_s      = 1'b0;

        case (state_q)
            IDLE: begin
                // Abort is meaningless here, so start always wins.
                if (start) begin
                    load_s  = 1'b1;
                    state_d = STREAM;
                end else begin
                    fetch_ptr_d = PTR_ZERO;
                end
            end

            STREAM: begin
                // Abort outranks a transfer in the same cycle; the consumer
                // still owns that beat, we just stop producing more.
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    fetch_ptr_d = PTR_ZERO;
                    state_d     = IDLE;
                end else if (xfer_s && !out_last_q) begin
                    load_s = 1'b1;
                end else if (xfer_s && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    fetch_ptr_d = PTR_ZERO;
                    state_d     = DONE;
                end else begin
                    state_d = STREAM;
                end
            end

            DONE: begin
                // A start seen here is dropped on purpose.
                state_d = IDLE;
            end

            default: begin
                // Illegal encoding: drop any beat and recover to IDLE.
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                fetch_ptr_d = PTR_ZERO;
            end
        endcase

        // The read data is captured at the same edge the pointer advances, so
        // a write landing on that edge is not seen by this beat.
        if (load_s) begin
            out_data_d  = rf_rdata;
            out_addr_d  = fetch_ptr_q;
            out_last_d  = (fetch_ptr_q == LAST_ADDR);
            out_valid_d = 1'b1;
            fetch_ptr_d = fetch_ptr_q + PTR_ONE;
        end else begin
            load_s = 1'b0;
        end

        busy_d = (state_d == STREAM);
        done_d = (state_d == DONE);
    end

    // State, pointer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_ptr_q <= PTR_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= DATA_ZERO;
            out_addr_q  <= PTR_ZERO;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rf_raddr  = fetch_ptr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_reader
// Directed bench for reg_dump_reader. A small register file model is the read
// target. Stimulus pushes the expected beats into a queue; a separate monitor
// pops and compares each accepted beat and also checks held beats stay stable.
// -----------------------------------------------------------------------------
module tb_reg_dump_reader;

    typedef struct {
        logic [1:0]  addr;
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [1:0]  rf_raddr;
    logic [63:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_addr;
    logic        out_last;

    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] rf [0:3];

    beat_t       exp_q[$];
    int          total;
    int          bad;
    int          beats_seen;
    int          done_cnt;

    reg_dump_reader #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last)
    );

    reg_dump_reader_chk #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) chk_i (
        .clk(clk), .rst_n(rst_n), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .done(done)
    );

    // Register file: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata = rf[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [1:0] a, input logic [63:0] d);
        beat_t b;
        b.addr = a;
        b.data = d;
        b.last = (a == 2'd3);
        exp_q.push_back(b);
    endtask

    task automatic push_dump(input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3);
        push_beat(2'd0, d0);
        push_beat(2'd1, d1);
        push_beat(2'd2, d2);
        push_beat(2'd3, d3);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [63:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        step();
        rf_we = 1'b0;
    endtask

    // Wait (bounded) for the done pulse, then check the dump's totals.
    task automatic finish_dump(input string name, input int b0, input int d0);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk({name, "_done_seen"}, 64'(done), 64'd1);
        step();
        chk({name, "_beats"}, 64'(beats_seen - b0), 64'd4);
        chk({name, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    // Monitor: compares accepted beats against the queue and checks stall stability.
    initial begin
        beat_t e;
        logic        stall;
        logic [63:0] held_data;
        logic [1:0]  held_addr;
        logic        held_last;
        stall = 1'b0;
        held_data = 64'd0; held_addr = 2'd0; held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", out_data, held_data);
                chk("stall_addr", 64'(out_addr), 64'(held_addr));
                chk("stall_last", 64'(out_last), 64'(held_last));
            end
            stall = 1'b0;
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got addr=%0d data=0x%0h, expected no beat",
                                 out_addr, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_addr", 64'(out_addr), 64'(e.addr));
                        chk("beat_data", out_data, e.data);
                        chk("beat_last", 64'(out_last), 64'(e.last));
                        beats_seen++;
                    end
                end
                if (done) done_cnt++;
                if (out_valid && !out_ready && !abort) begin
                    stall = 1'b1;
                    held_data = out_data;
                    held_addr = out_addr;
                    held_last = out_last;
                end
            end
        end
    end

    initial begin
        int b0;
        int d0;
        logic [3:0] pat;
        total = 0; bad = 0; beats_seen = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        rf_we = 1'b0; rf_waddr = 2'd0; rf_wdata = 64'd0;
        pat = 4'b1001;

        // Reset state.
        step(); step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_raddr", 64'(rf_raddr), 64'd0);
        rst_n = 1'b1;

        write_reg(2'd0, 64'h11); write_reg(2'd1, 64'h22);
        write_reg(2'd2, 64'h33); write_reg(2'd3, 64'h44);

        // Full-rate dump: one beat per cycle, done on the following cycle.
        b0 = beats_seen; d0 = done_cnt;
        push_dump(64'h11, 64'h22, 64'h33, 64'h44);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_first_valid", 64'(out_valid), 64'd1);
        chk("t1_first_addr", 64'(out_addr), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        step(); step(); step(); step();
        chk("t1_beats_in_4", 64'(beats_seen - b0), 64'd4);
        chk("t1_done_pulse", 64'(done), 64'd1);
        chk("t1_busy_in_done", 64'(busy), 64'd0);
        step();
        chk("t1_done_low", 64'(done), 64'd0);
        chk("t1_valid_low", 64'(out_valid), 64'd0);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Back-pressure 1,0,0,1: held beats stay stable, nothing lost or repeated.
        b0 = beats_seen; d0 = done_cnt;
        push_dump(64'h11, 64'h22, 64'h33, 64'h44);
        out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && done !== 1'b1; c++) begin
            out_ready = pat[c % 4];
            step();
        end
        finish_dump("t2", b0, d0);

        // Coherency: reg0 written while beat0 stalls, reg2 written before fetch.
        b0 = beats_seen; d0 = done_cnt;
        push_dump(64'h11, 64'h22, 64'hAA, 64'h44);
        out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        rf_we = 1'b1; rf_waddr = 2'd0; rf_wdata = 64'hBB;
        step();
        rf_we = 1'b1; rf_waddr = 2'd2; rf_wdata = 64'hAA; out_ready = 1'b1;
        step();
        rf_we = 1'b0;
        finish_dump("t3", b0, d0);

        // Abort with beat1 held and stalled.
        b0 = beats_seen; d0 = done_cnt;
        push_beat(2'd0, 64'hBB);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t4_held_addr", 64'(out_addr), 64'd1);
        out_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_valid_after_abort", 64'(out_valid), 64'd0);
        chk("t4_busy_after_abort", 64'(busy), 64'd0);
        chk("t4_done_after_abort", 64'(done), 64'd0);
        step(); step();
        chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t4_beats", 64'(beats_seen - b0), 64'd1);
        b0 = beats_seen; d0 = done_cnt;
        push_dump(64'hBB, 64'h22, 64'hAA, 64'h44);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_restart_addr", 64'(out_addr), 64'd0);
        finish_dump("t4", b0, d0);

        // Start while busy and during the done cycle is ignored.
        b0 = beats_seen; d0 = done_cnt;
        push_dump(64'hBB, 64'h22, 64'hAA, 64'h44);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("t5_done_pulse", 64'(done), 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("t5_beats", 64'(beats_seen - b0), 64'd4);
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_valid", 64'(out_valid), 64'd0);

        // Reset with beat2 held: everything clears, next dump is complete.
        b0 = beats_seen; d0 = done_cnt;
        push_beat(2'd0, 64'hBB);
        push_beat(2'd1, 64'h22);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("t6_held_addr", 64'(out_addr), 64'd2);
        out_ready = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_data", out_data, 64'd0);
        chk("t6_rst_addr", 64'(out_addr), 64'd0);
        chk("t6_rst_last", 64'(out_last), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_queue", 64'(exp_q.size()), 64'd0);
        b0 = beats_seen; d0 = done_cnt;
        push_dump(64'hBB, 64'h22, 64'hAA, 64'h44);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        finish_dump("t6", b0, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
